// File: rtl/datapath_pkg.sv
// Shared datapath constants and the 2-entry skid buffer state encoding.
package datapath_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/skid_buf2.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready and output payload.
module skid_buf2
  import datapath_pkg::*;
#(
  parameter int unsigned DW = 7
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  skid_state_e   state_q, state_d;
  logic [DW-1:0] out_q, out_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_ready_q, in_ready_d;
  logic          accept, xfer;

  assign in_ready  = in_ready_q;
  assign out_data  = out_q;
  // Derived from state so it drops together with the asynchronous reset.
  assign out_valid = (state_q != EMPTY);

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_d   = in_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          out_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/wr_dest_sel_pipe.sv
// Registered write-destination selector: picks one of N_IN fields, flags oob/zero,
// pipelines through a 2-entry skid buffer and counts out-of-range selects.
module wr_dest_sel_pipe
  import datapath_pkg::*;
#(
  parameter int unsigned W         = REG_ADDR_W,
  parameter int unsigned N_IN      = 5,
  parameter int unsigned SEL_W     = 3,
  parameter int unsigned ZERO_FLAG = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_IN*W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [W-1:0]      out_data,
  output logic              out_oob,
  output logic              out_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  oob_count,
  input  logic              cnt_clr
);

  logic [W-1:0]     sel_val;
  logic             oob, zero, accept;
  logic [W+1:0]     pay_out;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Out-of-range codes fall back to the last candidate.
  always_comb begin
    sel_val = in_data[(N_IN-1)*W +: W];
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (32'(in_sel) == k) sel_val = in_data[k*W +: W];
    end
    oob  = (32'(in_sel) >= N_IN);
    zero = (ZERO_FLAG != 0) && (sel_val == W'(REG_ZERO));
  end

  skid_buf2 #(.DW(W + 2)) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   ({oob, zero, sel_val}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (pay_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_oob  = pay_out[W+1];
  assign out_zero = pay_out[W];
  assign out_data = pay_out[W-1:0];

  assign accept = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (accept && oob && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign oob_count = cnt_q;

endmodule

// File: tb/tb_wr_dest_sel_pipe.sv
// Scoreboard bench: default DUT plus a ZERO_FLAG=0 / CNT_W=2 variant sharing stimulus.
module tb_wr_dest_sel_pipe;

  localparam int unsigned W = 5;
  localparam int unsigned N = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [N*W-1:0] in_data;
  logic [2:0]    in_sel;
  logic          in_valid, out_ready, cnt_clr;
  logic          in_ready, out_oob, out_zero, out_valid;
  logic [W-1:0]  out_data;
  logic [7:0]    oob_count;
  logic          in_ready1, out_oob1, out_zero1, out_valid1;
  logic [W-1:0]  out_data1;
  logic [1:0]    oob_count1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         oob;
    logic         zero;
  } exp_t;

  exp_t q[$];
  int   cnt0 = 0, cnt1 = 0;
  logic stable_pend = 1'b0;
  logic [W+1:0] prev_pay;

  always #5 clk = ~clk;

  wr_dest_sel_pipe dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_oob(out_oob), .out_zero(out_zero), .out_valid(out_valid),
    .out_ready(out_ready), .oob_count(oob_count), .cnt_clr(cnt_clr)
  );

  wr_dest_sel_pipe #(.ZERO_FLAG(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready1), .out_data(out_data1),
    .out_oob(out_oob1), .out_zero(out_zero1), .out_valid(out_valid1),
    .out_ready(out_ready), .oob_count(oob_count1), .cnt_clr(cnt_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [N*W-1:0] d, input logic [2:0] s);
    exp_t e;
    int   idx;
    idx    = (int'(s) < N) ? int'(s) : N - 1;
    e.data = d[idx*W +: W];
    e.oob  = (int'(s) >= N);
    e.zero = (e.data == 0);
    return e;
  endfunction

  // Monitor/scoreboard: evaluated mid-cycle, inputs and outputs are stable here.
  always @(negedge clk) begin
    int   occ;
    exp_t e, n;
    if (!reset_n) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_oob_zero", 32'({out_oob, out_zero}), 0);
      chk("rst_count", 32'(oob_count), 0);
      chk("rst_count1", 32'(oob_count1), 0);
      q.delete();
      cnt0 = 0;
      cnt1 = 0;
      stable_pend = 1'b0;
    end else begin
      occ = q.size();
      chk("in_ready", 32'(in_ready), 32'(occ < 2));
      chk("out_valid", 32'(out_valid), 32'(occ > 0));
      chk("in_ready1", 32'(in_ready1), 32'(occ < 2));
      chk("out_valid1", 32'(out_valid1), 32'(occ > 0));
      chk("oob_count", 32'(oob_count), 32'(cnt0));
      chk("oob_count1", 32'(oob_count1), 32'(cnt1));
      if (stable_pend) chk("held_stable", 32'({out_oob, out_zero, out_data}), 32'(prev_pay));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          chk("out_data", 32'(out_data), 32'(e.data));
          chk("out_oob", 32'(out_oob), 32'(e.oob));
          chk("out_zero", 32'(out_zero), 32'(e.zero));
          chk("out_data1", 32'(out_data1), 32'(e.data));
          chk("out_oob1", 32'(out_oob1), 32'(e.oob));
          chk("out_zero1", 32'(out_zero1), 0);
        end
      end
      stable_pend = out_valid && !out_ready;
      prev_pay    = {out_oob, out_zero, out_data};
      if (in_valid && occ < 2) begin
        n = model(in_data, in_sel);
        q.push_back(n);
      end
      if (cnt_clr) begin
        cnt0 = 0;
        cnt1 = 0;
      end else if (in_valid && occ < 2 && int'(in_sel) >= N) begin
        if (cnt0 < 255) cnt0++;
        if (cnt1 < 3)   cnt1++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] s);
    logic a;
    int   n;
    in_valid = 1'b1;
    in_sel   = s;
    n = 0;
    do begin
      a = in_ready;
      step();
      n++;
    end while (!a && n < 50);
    chk("accept_in_time", 32'(a), 1);
    in_valid = 1'b0;
  endtask

  function automatic logic [N*W-1:0] pack5(input int a, b, c, d, e);
    return {5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 3'd2;
    in_data   = pack5(1, 2, 3, 4, 5);
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    repeat (3) step();
    in_valid = 1'b0;
    reset_n  = 1'b1;

    // In-range sweep, back-to-back
    in_data = pack5(10, 11, 12, 13, 14);
    for (int unsigned s = 0; s < N; s++) send(3'(s));
    // Out-of-range codes fall back to candidate N-1
    for (int unsigned s = 5; s < 8; s++) send(3'(s));
    step();
    chk("count_after_3oob", 32'(oob_count), 3);
    cnt_clr = 1'b1;
    send(3'd7);
    cnt_clr = 1'b0;
    step();
    chk("count_after_clr", 32'(oob_count), 0);

    // Backpressure: A then B held, then released in order
    out_ready = 1'b0;
    in_data = pack5(21, 22, 23, 24, 25);
    send(3'd0);
    send(3'd1);
    chk("bp_in_ready_low", 32'(in_ready), 0);
    chk("bp_data_A", 32'(out_data), 21);
    repeat (3) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Zero flag
    in_data = pack5(7, 0, 9, 9, 9);
    send(3'd1);
    chk("zero_flag_on", 32'(out_zero), 1);
    chk("zero_flag_off", 32'(out_zero1), 0);
    step();

    // Saturation of the narrow counter
    for (int i = 0; i < 5; i++) send(3'd6);
    step();
    chk("sat_count1", 32'(oob_count1), 3);
    chk("count0_5", 32'(oob_count), 5);

    // Reset while FULL: both held entries discarded
    out_ready = 1'b0;
    in_data = pack5(3, 4, 5, 6, 8);
    send(3'd2);
    send(3'd3);
    chk("full_before_rst", 32'(in_ready), 0);
    reset_n = 1'b0;
    #1;
    chk("async_drop", 32'(out_valid), 0);
    chk("async_drop1", 32'(out_valid1), 0);
    step();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    repeat (3) step();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 3'($urandom);
      in_data   = (N*W)'($urandom) & (N*W)'($urandom | $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 40) == 0);
      step();
    end
    in_valid  = 1'b0;
    cnt_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("drained", 32'(q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wr_dest_sel_pipe.md
Name: wr_dest_sel_pipe

Overview:
- Parametrised, registered successor to the register-file write-destination selector.
- Picks one of N_IN candidate destination fields (W bits each) by a select code.
- Carries the selected value through a valid/ready pipeline stage with a 2-entry skid buffer.
- Flags out-of-range selects and write-to-zero destinations, and keeps a saturating count of out-of-range selects.
- Sits between the control unit's destination-select outputs and the register-file write port in the multicycle datapath.

Parameters:
- W, 5, width of each destination field.
- N_IN, 5, number of candidate inputs (2..16).
- SEL_W, 3, select width; must satisfy 2^SEL_W >= N_IN.
- ZERO_FLAG, 1, when 1, out_zero is computed; when 0, out_zero is tied to 0.
- CNT_W, 8, width of the out-of-range counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_data  in  N_IN*W  flattened candidates; candidate k occupies bits [k*W +: W]
- in_sel  in  SEL_W  select code
- in_valid  in  1  producer has a request this cycle
- in_ready  out  1  block can accept this cycle
- out_data  out  W  selected destination
- out_oob  out  1  this entry was produced by an out-of-range select
- out_zero  out  1  out_data == 0 (gated by ZERO_FLAG)
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts the output entry
- oob_count  out  CNT_W  saturating count of accepted out-of-range selects
- cnt_clr  in  1  synchronous clear of oob_count

Behaviour:
- Clocking and reset:
  - One clock domain (clk); reset_n is asynchronous and active-low.
  - Reset values: out_valid=0, out_data=0, out_oob=0, out_zero=0, oob_count=0, skid empty, in_ready=1 (in_ready is high during and immediately after reset).
- Selection (combinational, before registering):
  - If in_sel < N_IN: sel_val = candidate[in_sel], oob = 0.
  - Otherwise: sel_val = candidate[N_IN-1], oob = 1.
  - zero = ZERO_FLAG && (sel_val == 0).
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - in_ready = !skid_full, and it is a registered signal.
  - in_data and in_sel are don't-care when in_valid=0.
- State machine:
  - EMPTY
    - accept -> load output regs, go to ONE.
  - ONE
    - accept && transfer -> reload output regs from the new entry, stay in ONE.
    - accept && !transfer -> write the new entry to the skid, go to FULL; in_ready falls the next cycle.
    - transfer only -> go to EMPTY.
  - FULL
    - No accept is possible.
    - transfer -> move skid to output regs, go to ONE, in_ready rises.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge t is on out_data after edge t.
  - Sustained throughput is 1 per cycle while out_ready=1.
  - No bubble when out_ready stays high.
- Ordering and integrity:
  - Output order is strictly input order.
  - No entry is dropped or duplicated.
  - out_data, out_oob and out_zero are held stable while out_valid && !out_ready.
- Counter:
  - oob_count increments by 1 on each accept with oob=1.
  - It saturates at 2^CNT_W-1.
  - cnt_clr has priority: if cnt_clr and an oob accept occur in the same cycle, the next value is 0.
  - The count is independent of the output handshake.
- Reset mid-operation:
  - Asserting reset_n=0 discards both held entries immediately.
  - out_valid drops asynchronously.
- Boundaries:
  - in_sel = N_IN-1 is in range (oob=0).
  - in_sel = 2^SEL_W-1 is out of range whenever it is >= N_IN.
  - When N_IN = 2^SEL_W, oob is never set.

Decomposition:
- Shared package (datapath_pkg):
  - Constants REG_ADDR_W=5 and REG_ZERO=0.
  - Skid state encoding EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One natural sub-module, skid_buf2:
  - A generic 2-entry valid/ready skid buffer with parameter DW.
  - Payload is {oob, zero, data}, so DW = W+2.
- The top level holds the selection logic and the counter.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> out_valid=0, oob_count=0, in_ready=1; release -> first accept appears 1 cycle later.
- In-range sweep (defaults): candidates 5'd10..5'd14, in_sel 0..4 with out_ready=1 -> out_data 10,11,12,13,14 on consecutive cycles, out_oob=0 throughout.
- Out-of-range: in_sel=5,6,7 -> out_data=14, out_oob=1 each; oob_count=3; then cnt_clr together with an in_sel=7 accept -> oob_count=0.
- Backpressure:
  - out_ready=0, send A then B -> in_ready=0 after B, out_data=A held stable.
  - Raise out_ready -> A, then B, in order; in_ready=1 one cycle after A transfers.
- Zero flag: candidate[1]=0, in_sel=1 -> out_zero=1; with ZERO_FLAG=0 -> out_zero=0.
- Saturation and mid-operation reset:
  - CNT_W=2, 5 oob accepts -> oob_count=3.
  - Reset asserted in FULL state -> out_valid=0 immediately, skid contents never emitted.
